// File: rtl/pueo_time_pkg.sv
// Shared types for the sys_clk PPS timing core: FSM states and source-mode encodings.
package pueo_time_pkg;

  typedef enum logic [1:0] {
    INT      = 2'd0,
    ARMED    = 2'd1,
    HOLD     = 2'd2,
    FALLBACK = 2'd3
  } pps_state_t;

  localparam logic [1:0] MODE_INT    = 2'd0;
  localparam logic [1:0] MODE_EXT    = 2'd1;
  localparam logic [1:0] MODE_EXT_FB = 2'd2;

  // Mode 3 is treated exactly like mode 0.
  function automatic logic is_ext_mode(input logic [1:0] mode);
    return (mode == MODE_EXT) || (mode == MODE_EXT_FB);
  endfunction

endpackage

// File: rtl/pueo_pps_edge_sync.sv
// Synchronises the raw external PPS inputs, picks the selected channel and
// produces a single-cycle rising-edge pulse on it.
module pueo_pps_edge_sync #(
  parameter int NUM_PPS = 2,
  parameter int SEL_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_PPS-1:0] pps,
  input  logic [SEL_W-1:0]   sel,
  output logic               rise
);

  logic [NUM_PPS-1:0]  meta;
  logic [NUM_PPS-1:0]  sync;
  logic [2**SEL_W-1:0] sync_pad;
  logic                sel_bit;
  logic                sel_bit_d;

  // Unpopulated select codes read as a quiet (low) input.
  always_comb begin
    sync_pad              = '0;
    sync_pad[NUM_PPS-1:0] = sync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta      <= '0;
      sync      <= '0;
      sel_bit   <= 1'b0;
      sel_bit_d <= 1'b0;
    end else begin
      meta      <= pps;
      sync      <= meta;
      sel_bit   <= sync_pad[sel];
      sel_bit_d <= sel_bit;
    end
  end

  assign rise = sel_bit & ~sel_bit_d;

endmodule

// File: rtl/pueo_pps_timestamper.sv
// PPS source selection with holdoff, missing-PPS detection/fallback, seconds and
// free-running time counters, and a short history of PPS timestamps.
module pueo_pps_timestamper
  import pueo_time_pkg::*;
#(
  parameter int NUM_PPS       = 2,
  parameter int TIME_W        = 32,
  parameter int SEC_W         = 32,
  parameter int HIST_DEPTH    = 4,
  parameter int HOLDOFF_SHIFT = 12,
  parameter int TIMEOUT_CYC   = 130000000,
  localparam int SEL_W = (NUM_PPS > 1) ? $clog2(NUM_PPS) : 1,
  localparam int IDX_W = $clog2(HIST_DEPTH)
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  input  logic [NUM_PPS-1:0] pps_i,
  input  logic [SEL_W-1:0]   pps_sel_i,
  input  logic [1:0]         mode_i,
  input  logic               int_pps_i,
  input  logic [15:0]        holdoff_i,
  input  logic               runrst_i,
  input  logic               load_sec_i,
  input  logic [SEC_W-1:0]   update_sec_i,
  input  logic [IDX_W-1:0]   hist_idx_i,
  output logic               pps_flag_o,
  output logic               pps_pulse_o,
  output logic [SEC_W-1:0]   cur_sec_o,
  output logic [TIME_W-1:0]  cur_time_o,
  output logic [TIME_W-1:0]  hist_o,
  output logic               pps_missing_o,
  output logic               using_int_o,
  output logic [7:0]         missing_cnt_o
);

  localparam int HOLD_W = 16 + HOLDOFF_SHIFT;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);

  pps_state_t        state;
  pps_state_t        state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_reload;
  logic [TO_W-1:0]   to_cnt;
  logic              rise;
  logic              flag_next;
  logic              load_hold;
  logic              timeout;
  logic [TIME_W-1:0] hist [HIST_DEPTH];

  pueo_pps_edge_sync #(
    .NUM_PPS (NUM_PPS),
    .SEL_W   (SEL_W)
  ) u_edge_sync (
    .clk  (sys_clk_i),
    .rst  (sys_rst_i),
    .pps  (pps_i),
    .sel  (pps_sel_i),
    .rise (rise)
  );

  // holdoff_i = 0 still yields 2^HOLDOFF_SHIFT cycles of holdoff.
  assign hold_reload = {holdoff_i, {HOLDOFF_SHIFT{1'b1}}};
  assign timeout     = !rise && (to_cnt == TO_LAST);

  always_comb begin
    state_next = state;
    flag_next  = 1'b0;
    load_hold  = 1'b0;
    case (state)
      INT: begin
        flag_next = int_pps_i;
        if (is_ext_mode(mode_i)) state_next = ARMED;
      end
      ARMED: begin
        flag_next = rise;
        if (rise) begin
          state_next = HOLD;
          load_hold  = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) state_next = ARMED;
      end
      FALLBACK: begin
        flag_next = int_pps_i | rise;
        if (rise) begin
          state_next = HOLD;
          load_hold  = 1'b1;
        end
      end
      default: state_next = INT;
    endcase
    if (timeout && (mode_i == MODE_EXT_FB) && (state == ARMED || state == HOLD)) begin
      state_next = FALLBACK;
      load_hold  = 1'b0;
    end
    if (!is_ext_mode(mode_i)) begin
      state_next = INT;
      load_hold  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state       <= INT;
      hold_cnt    <= '0;
      pps_flag_o  <= 1'b0;
      pps_pulse_o <= 1'b0;
      using_int_o <= 1'b0;
    end else begin
      state       <= state_next;
      pps_flag_o  <= flag_next;
      pps_pulse_o <= (state_next == HOLD);
      using_int_o <= (state_next == INT) || (state_next == FALLBACK);
      if (load_hold)
        hold_cnt <= hold_reload;
      else if (state == HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Timeout counter saturates so the missing event fires only once per outage.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      to_cnt        <= '0;
      pps_missing_o <= 1'b0;
      missing_cnt_o <= '0;
    end else begin
      if (rise)
        to_cnt <= '0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + 1'b1;
      if (rise)
        pps_missing_o <= 1'b0;
      else if (timeout)
        pps_missing_o <= 1'b1;
      if (timeout && missing_cnt_o != 8'hFF)
        missing_cnt_o <= missing_cnt_o + 8'd1;
    end
  end

  // History and seconds update on the registered flag, so hist[0] holds the
  // cur_time value visible while pps_flag_o is high.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      cur_sec_o  <= '0;
      cur_time_o <= '0;
      hist_o     <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) hist[k] <= '0;
    end else begin
      if (load_sec_i)
        cur_sec_o <= update_sec_i;
      else if (pps_flag_o)
        cur_sec_o <= cur_sec_o + 1'b1;
      cur_time_o <= runrst_i ? '0 : cur_time_o + 1'b1;
      if (pps_flag_o) begin
        for (int k = HIST_DEPTH - 1; k > 0; k--) hist[k] <= hist[k-1];
        hist[0] <= cur_time_o;
      end
      if (int'(hist_idx_i) < HIST_DEPTH)
        hist_o <= hist[hist_idx_i];
      else
        hist_o <= '0;
    end
  end

endmodule

// File: tb/tb_pueo_pps_timestamper.sv
// Randomised and directed bench for pueo_pps_timestamper against a timestamp-based reference model.
module tb_pueo_pps_timestamper;

  localparam int NUM_PPS       = 2;
  localparam int TIME_W        = 32;
  localparam int SEC_W         = 32;
  localparam int HIST_DEPTH    = 4;
  localparam int HOLDOFF_SHIFT = 12;
  localparam int TIMEOUT_CYC   = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  pps = '0;
  logic [0:0]  pps_sel = '0;
  logic [1:0]  mode = '0;
  logic        int_pps = 1'b0;
  logic [15:0] holdoff = '0;
  logic        runrst = 1'b0;
  logic        load_sec = 1'b0;
  logic [31:0] update_sec = '0;
  logic [1:0]  hist_idx = '0;

  logic        pps_flag;
  logic        pps_pulse;
  logic [31:0] cur_sec;
  logic [31:0] cur_time;
  logic [31:0] hist_out;
  logic        pps_missing;
  logic        using_int;
  logic [7:0]  missing_cnt;

  always #5 clk = ~clk;

  pueo_pps_timestamper #(
    .NUM_PPS       (NUM_PPS),
    .TIME_W        (TIME_W),
    .SEC_W         (SEC_W),
    .HIST_DEPTH    (HIST_DEPTH),
    .HOLDOFF_SHIFT (HOLDOFF_SHIFT),
    .TIMEOUT_CYC   (TIMEOUT_CYC)
  ) dut (
    .sys_clk_i     (clk),
    .sys_rst_i     (rst),
    .pps_i         (pps),
    .pps_sel_i     (pps_sel),
    .mode_i        (mode),
    .int_pps_i     (int_pps),
    .holdoff_i     (holdoff),
    .runrst_i      (runrst),
    .load_sec_i    (load_sec),
    .update_sec_i  (update_sec),
    .hist_idx_i    (hist_idx),
    .pps_flag_o    (pps_flag),
    .pps_pulse_o   (pps_pulse),
    .cur_sec_o     (cur_sec),
    .cur_time_o    (cur_time),
    .hist_o        (hist_out),
    .pps_missing_o (pps_missing),
    .using_int_o   (using_int),
    .missing_cnt_o (missing_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int obs_flags = 0;

  // Reference model: time-stamped view of the spec (cycle index j counts posedges since reset).
  int          j;
  logic [1:0]  ppsh[$];
  int          selh[$];
  int          m_st;          // 0 INT, 1 ARMED, 2 HOLD, 3 FALLBACK
  longint      m_hold_end;
  longint      m_last_clear;
  bit          m_miss;
  int          m_mcnt;
  bit          m_flag;
  bit          m_pulse;
  bit          m_uint;
  logic [31:0] m_sec;
  logic [31:0] m_time;
  logic [31:0] m_hout;
  logic [31:0] m_hist [4];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, j);
    end
  endtask

  function automatic bit sel_level(int m);
    if (m < 3) return 1'b0;
    return ppsh[m-2][selh[m]];
  endfunction

  task automatic model_reset();
    ppsh.delete();
    selh.delete();
    ppsh.push_back(2'b00);
    selh.push_back(0);
    j = 0;
    m_st = 0; m_hold_end = 0; m_last_clear = 0;
    m_miss = 0; m_mcnt = 0; m_flag = 0; m_pulse = 0; m_uint = 0;
    m_sec = '0; m_time = '0; m_hout = '0;
    for (int k = 0; k < 4; k++) m_hist[k] = '0;
  endtask

  task automatic model_step();
    bit     e, fl, tmo;
    int     ns;
    longint r;
    j++;
    ppsh.push_back(pps);
    selh.push_back(int'(pps_sel));
    e = sel_level(j - 1) && !sel_level(j - 2);
    case (m_st)
      0:       fl = int_pps;
      1:       fl = e;
      2:       fl = 1'b0;
      default: fl = int_pps || e;
    endcase
    tmo = !e && ((longint'(j) - m_last_clear) == TIMEOUT_CYC);
    r = longint'(holdoff) * (64'd1 << HOLDOFF_SHIFT) + (64'd1 << HOLDOFF_SHIFT) - 1;
    ns = m_st;
    if (mode == 2'd0 || mode == 2'd3) ns = 0;
    else if (tmo && mode == 2'd2 && (m_st == 1 || m_st == 2)) ns = 3;
    else begin
      case (m_st)
        0: ns = 1;
        1: if (fl) begin ns = 2; m_hold_end = j + r + 1; end
        2: if (j >= m_hold_end) ns = 1;
        default: if (e) begin ns = 2; m_hold_end = j + r + 1; end
      endcase
    end
    m_hout = m_hist[hist_idx];
    if (m_flag) begin
      for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_time;
    end
    if (load_sec) m_sec = update_sec;
    else if (m_flag) m_sec = m_sec + 1;
    m_time = runrst ? 32'd0 : m_time + 1;
    if (e) begin
      m_miss = 0;
      m_last_clear = j;
    end else if (tmo) begin
      m_miss = 1;
      if (m_mcnt < 255) m_mcnt++;
    end
    m_flag  = fl;
    m_st    = ns;
    m_pulse = (ns == 2);
    m_uint  = (ns == 0 || ns == 3);
    if (fl) $display("pps event: cycle %0d mode %0d state %0d time 0x%0h", j, mode, ns, m_time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_eq("flag",     64'(pps_flag),    64'(m_flag));
    check_eq("pulse",    64'(pps_pulse),   64'(m_pulse));
    check_eq("using_int",64'(using_int),   64'(m_uint));
    check_eq("missing",  64'(pps_missing), 64'(m_miss));
    check_eq("miss_cnt", 64'(missing_cnt), 64'(m_mcnt));
    check_eq("cur_sec",  64'(cur_sec),     64'(m_sec));
    check_eq("cur_time", 64'(cur_time),    64'(m_time));
    check_eq("hist_o",   64'(hist_out),    64'(m_hout));
    if (pps_flag) obs_flags++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    pps = '0; int_pps = 1'b0; runrst = 1'b0; load_sec = 1'b0;
    #1;
    check_eq("rst_flag",     64'(pps_flag),    64'd0);
    check_eq("rst_pulse",    64'(pps_pulse),   64'd0);
    check_eq("rst_using_int",64'(using_int),   64'd0);
    check_eq("rst_missing",  64'(pps_missing), 64'd0);
    check_eq("rst_miss_cnt", 64'(missing_cnt), 64'd0);
    check_eq("rst_sec",      64'(cur_sec),     64'd0);
    check_eq("rst_time",     64'(cur_time),    64'd0);
    check_eq("rst_hist",     64'(hist_out),    64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic read_hist(input int idx, output logic [31:0] val);
    hist_idx = 2'(idx);
    tick();
    val = hist_out;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1);
  end

  initial begin
    logic [31:0] h0, h1, hv;
    longint      exp_t [5];
    longint      c;
    int          waited;

    model_reset();
    #2;
    reset_dut();

    // Internal PPS every 1000 cycles.
    mode = 2'd0;
    obs_flags = 0;
    for (int p = 0; p < 5; p++) begin
      int_pps = 1'b1; tick(); int_pps = 1'b0;
      repeat (999) tick();
    end
    check_eq("t1_flag_count", 64'(obs_flags), 64'd5);
    check_eq("t1_sec", 64'(cur_sec), 64'd5);
    read_hist(0, h0);
    read_hist(1, h1);
    check_eq("t1_hist_step", 64'(h0 - h1), 64'd1000);

    // Seconds load beats a same-cycle flag, and seconds wrap.
    int_pps = 1'b1; tick(); int_pps = 1'b0;
    load_sec = 1'b1; update_sec = 32'h1234_5678; tick(); load_sec = 1'b0;
    check_eq("t4_load_wins", 64'(cur_sec), 64'h1234_5678);
    load_sec = 1'b1; update_sec = 32'hFFFF_FFFF; tick(); load_sec = 1'b0;
    int_pps = 1'b1; tick(); int_pps = 1'b0; tick();
    check_eq("t4_sec_wrap", 64'(cur_sec), 64'd0);

    // History ordering and runrst capture.
    reset_dut();
    mode = 2'd0;
    for (int p = 0; p < 5; p++) begin
      repeat ($urandom_range(50, 200)) tick();
      int_pps = 1'b1; tick(); exp_t[p] = j; int_pps = 1'b0;
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      read_hist(k, hv);
      check_eq($sformatf("t5_hist%0d", k), 64'(hv), 64'(exp_t[4-k]));
    end
    int_pps = 1'b1; tick(); c = j; int_pps = 1'b0;
    runrst = 1'b1; tick(); runrst = 1'b0;
    read_hist(0, hv);
    check_eq("t5_runrst_capture", 64'(hv), 64'(c));

    // External mode with holdoff 1: glitch ignored, later edge flagged 4 cycles on.
    reset_dut();
    mode = 2'd1; holdoff = 16'd1; pps_sel = 1'b0;
    repeat (10) tick();
    obs_flags = 0;
    pps[0] = 1'b1; repeat (50) tick(); pps[0] = 1'b0; repeat (50) tick();
    pps[0] = 1'b1; repeat (3) tick(); pps[0] = 1'b0;
    repeat (8300 - 103) tick();
    pps[0] = 1'b1; repeat (3) tick();
    check_eq("t2_lat3", 64'(pps_flag), 64'd0);
    tick();
    check_eq("t2_lat4", 64'(pps_flag), 64'd1);
    repeat (46) tick(); pps[0] = 1'b0; repeat (20) tick();
    check_eq("t2_flag_count", 64'(obs_flags), 64'd2);

    // Fallback to internal PPS on timeout, recovery on a restored edge.
    reset_dut();
    mode = 2'd2; holdoff = 16'd0; pps_sel = 1'b1;
    repeat (5) tick();
    pps[1] = 1'b1; repeat (50) tick(); pps[1] = 1'b0;
    waited = 0;
    while (!pps_missing && waited < 6000) begin
      tick();
      waited++;
    end
    check_eq("t3_missing", 64'(pps_missing), 64'd1);
    check_eq("t3_using_int", 64'(using_int), 64'd1);
    check_eq("t3_miss_cnt", 64'(missing_cnt), 64'd1);
    repeat (20) tick();
    pps[1] = 1'b1; repeat (4) tick();
    check_eq("t3_restore_flag", 64'(pps_flag), 64'd1);
    check_eq("t3_restore_missing", 64'(pps_missing), 64'd0);
    check_eq("t3_restore_hold", 64'(pps_pulse), 64'd1);
    repeat (40) tick(); pps[1] = 1'b0; tick();

    // Reset in the middle of a holdoff, then resume.
    reset_dut();
    mode = 2'd1; holdoff = 16'd0; pps_sel = 1'b0;
    repeat (5) tick();
    pps[0] = 1'b1; repeat (50) tick(); pps[0] = 1'b0; repeat (50) tick();
    check_eq("t6_in_hold", 64'(pps_pulse), 64'd1);
    reset_dut();
    repeat (5) tick();
    obs_flags = 0;
    pps[0] = 1'b1; repeat (4) tick();
    check_eq("t6_first_edge", 64'(pps_flag), 64'd1);
    repeat (30) tick(); pps[0] = 1'b0; tick();

    // Random segments across all modes and channels.
    reset_dut();
    for (int seg = 0; seg < 8; seg++) begin
      mode    = 2'($urandom_range(0, 3));
      pps_sel = 1'($urandom_range(0, 1));
      holdoff = 16'($urandom_range(0, 1));
      repeat (1500) begin
        for (int ch = 0; ch < NUM_PPS; ch++)
          if ($urandom_range(0, 299) == 0) pps[ch] = ~pps[ch];
        int_pps    = ($urandom_range(0, 399) == 0);
        runrst     = ($urandom_range(0, 499) == 0);
        load_sec   = ($urandom_range(0, 699) == 0);
        update_sec = $urandom;
        hist_idx   = 2'($urandom_range(0, 3));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
